// File: rtl/aclk_timegen.sv
// Alarm-clock time base: prescaler, one_second/one_minute strobes and BCD seconds.
// Optional freeze input enabled by defining ACLK_TIMEGEN_HOLD_EN.
module aclk_timegen #(
   parameter int CLK_PER_SEC = 256,
   parameter int SEC_PER_MIN = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       reset_count,
   input  logic       fast_watch,
`ifdef ACLK_TIMEGEN_HOLD_EN
   input  logic       hold,
`endif
   output logic       one_second,
   output logic       one_minute,
   output logic [3:0] sec_ms,
   output logic [3:0] sec_ls
);

   localparam int               CNT_W    = $clog2(CLK_PER_SEC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_SEC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [3:0]       MS_LAST  = 4'((SEC_PER_MIN - 1) / 10);
   localparam logic [3:0]       LS_LAST  = 4'((SEC_PER_MIN - 1) % 10);

   // True when both digits form a reachable seconds value (00..59).
   function automatic logic bcd_sec_legal(input logic [3:0] ms, input logic [3:0] ls);
      logic ok;
      if ((ms > MS_LAST) || (ls > 4'd9)) begin
         ok = 1'b0;
      end else begin
         ok = 1'b1;
      end
      return ok;
   endfunction

   // Next seconds value {ms, ls}; illegal or last-second states restart at 00.
   function automatic logic [7:0] bcd_sec_inc(input logic [3:0] ms, input logic [3:0] ls);
      logic [7:0] nxt;
      if (!bcd_sec_legal(ms, ls)) begin
         nxt = 8'h00;
      end else if (ls < 4'd9) begin
         nxt = {ms, ls + 4'd1};
      end else if (ms < MS_LAST) begin
         nxt = {ms + 4'd1, 4'd0};
      end else begin
         nxt = 8'h00;
      end
      return nxt;
   endfunction

   logic [CNT_W-1:0] cnt_r;
   logic [3:0]       sec_ms_r;
   logic [3:0]       sec_ls_r;
   logic             one_second_r;
   logic             one_minute_r;

   logic [CNT_W-1:0] cnt_nxt_s;
   logic [3:0]       sec_ms_nxt_s;
   logic [3:0]       sec_ls_nxt_s;
   logic             one_second_nxt_s;
   logic             one_minute_nxt_s;
   logic [7:0]       sec_inc_s;
   logic             tick_s;
   logic             sec_last_s;
   logic             hold_s;

`ifdef ACLK_TIMEGEN_HOLD_EN
   assign hold_s = hold;
`else
   assign hold_s = 1'b0;
`endif

   assign tick_s     = (cnt_r == CNT_LAST);
   assign sec_last_s = (sec_ms_r == MS_LAST) && (sec_ls_r == LS_LAST);
   assign sec_inc_s  = bcd_sec_inc(sec_ms_r, sec_ls_r);

   // Next-state selection: restart, freeze, then normal counting.
   always_comb begin
      cnt_nxt_s        = cnt_r;
      sec_ms_nxt_s     = sec_ms_r;
      sec_ls_nxt_s     = sec_ls_r;
      one_second_nxt_s = 1'b0;
      one_minute_nxt_s = 1'b0;
      if (reset_count) begin
         cnt_nxt_s    = CNT_ZERO;
         sec_ms_nxt_s = 4'd0;
         sec_ls_nxt_s = 4'd0;
      end else if (hold_s) begin
         cnt_nxt_s = cnt_r;
      end else if (tick_s) begin
         cnt_nxt_s        = CNT_ZERO;
         sec_ms_nxt_s     = sec_inc_s[7:4];
         sec_ls_nxt_s     = sec_inc_s[3:0];
         one_second_nxt_s = 1'b1;
         // fast_watch only gates the strobe; the seconds count is unaffected
         one_minute_nxt_s = fast_watch | sec_last_s;
      end else begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r        <= CNT_ZERO;
         sec_ms_r     <= 4'd0;
         sec_ls_r     <= 4'd0;
         one_second_r <= 1'b0;
         one_minute_r <= 1'b0;
      end else begin
         cnt_r        <= cnt_nxt_s;
         sec_ms_r     <= sec_ms_nxt_s;
         sec_ls_r     <= sec_ls_nxt_s;
         one_second_r <= one_second_nxt_s;
         one_minute_r <= one_minute_nxt_s;
      end
   end

   assign one_second = one_second_r;
   assign one_minute = one_minute_r;
   assign sec_ms     = sec_ms_r;
   assign sec_ls     = sec_ls_r;

endmodule

// File: tb/tb_aclk_timegen.sv
// Directed bench for aclk_timegen with CLK_PER_SEC=4.
module tb_aclk_timegen;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       reset_count = 1'b0;
   logic       fast_watch = 1'b0;
   logic       hold = 1'b0;
   logic       one_second;
   logic       one_minute;
   logic [3:0] sec_ms;
   logic [3:0] sec_ls;

   int n_checks = 0;
   int n_fail   = 0;

   aclk_timegen #(.CLK_PER_SEC(4), .SEC_PER_MIN(60)) dut (
      .clk         (clk),
      .reset       (reset),
      .reset_count (reset_count),
      .fast_watch  (fast_watch),
`ifdef ACLK_TIMEGEN_HOLD_EN
      .hold        (hold),
`endif
      .one_second  (one_second),
      .one_minute  (one_minute),
      .sec_ms      (sec_ms),
      .sec_ls      (sec_ls)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_sec(input string tag, input logic [3:0] ms, input logic [3:0] ls);
      check({tag, "_ms"}, {28'd0, sec_ms}, {28'd0, ms});
      check({tag, "_ls"}, {28'd0, sec_ls}, {28'd0, ls});
   endtask

   initial begin
      int os_cnt;
      int om_cnt;
      int om_edge;
      int om_with_os;

      // Reset state before any clock edge
      #1 reset = 1'b1;
      #1;
      check("rst_os", {31'd0, one_second}, 32'd0);
      check("rst_om", {31'd0, one_minute}, 32'd0);
      check_sec("rst_sec", 4'd0, 4'd0);
      step(2);
      reset = 1'b0;

      // 1. Run to cnt=2, sec=3/7, then asynchronous reset between edges
      step(150);
      check_sec("t1_pre", 4'd3, 4'd7);
      #2 reset = 1'b1;
      #1;
      check_sec("t1_async", 4'd0, 4'd0);
      check("t1_async_os", {31'd0, one_second}, 32'd0);
      check("t1_async_om", {31'd0, one_minute}, 32'd0);
      #2 reset = 1'b0;
      step(3);
      check("t1_os_e3", {31'd0, one_second}, 32'd0);
      step(1);
      check("t1_os_e4", {31'd0, one_second}, 32'd1);
      check_sec("t1_sec_e4", 4'd0, 4'd1);
      step(1);
      check("t1_os_e5", {31'd0, one_second}, 32'd0);

      // 2. Free run 240 edges from a fresh reset
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      os_cnt = 0; om_cnt = 0; om_edge = 0; om_with_os = 0;
      for (int i = 1; i <= 240; i++) begin
         step(1);
         if (one_second === 1'b1) os_cnt++;
         if (one_minute === 1'b1) begin
            om_cnt++;
            om_edge = i;
            if (one_second === 1'b1) om_with_os++;
         end
         if (i == 236) check_sec("t2_sec59", 4'd5, 4'd9);
      end
      check("t2_os_count", os_cnt, 32'd60);
      check("t2_om_count", om_cnt, 32'd1);
      check("t2_om_edge", om_edge, 32'd240);
      check("t2_om_with_os", om_with_os, 32'd1);
      check_sec("t2_sec_wrap", 4'd0, 4'd0);

      // 3. fast_watch for 3 seconds
      fast_watch = 1'b1;
      om_cnt = 0; om_with_os = 0;
      for (int i = 1; i <= 12; i++) begin
         step(1);
         if (one_minute === 1'b1) begin
            om_cnt++;
            if (one_second === 1'b1) om_with_os++;
         end
      end
      fast_watch = 1'b0;
      check("t3_om_count", om_cnt, 32'd3);
      check("t3_om_with_os", om_with_os, 32'd3);
      check_sec("t3_sec", 4'd0, 4'd3);

      // 4. reset_count colliding with the tick at cnt=3, sec=2/5
      step(91);
      check_sec("t4_pre", 4'd2, 4'd5);
      reset_count = 1'b1;
      step(1);
      reset_count = 1'b0;
      check("t4_os", {31'd0, one_second}, 32'd0);
      check("t4_om", {31'd0, one_minute}, 32'd0);
      check_sec("t4_sec", 4'd0, 4'd0);
      step(3);
      check("t4_os_e3", {31'd0, one_second}, 32'd0);
      step(1);
      check("t4_os_e4", {31'd0, one_second}, 32'd1);
      check_sec("t4_sec_e4", 4'd0, 4'd1);

`ifdef ACLK_TIMEGEN_HOLD_EN
      // 5. hold for 10 cycles at cnt=1
      step(1);
      hold = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step(1);
         check("t5_hold_os", {31'd0, one_second}, 32'd0);
         check_sec("t5_hold_sec", 4'd0, 4'd1);
      end
      hold = 1'b0;
      step(2);
      check("t5_os_e12", {31'd0, one_second}, 32'd0);
      step(1);
      check("t5_os_e13", {31'd0, one_second}, 32'd1);
      check_sec("t5_sec", 4'd0, 4'd2);
`endif

      // 6. fast_watch toggled around the tick at sec=5/9
      reset_count = 1'b1;
      step(1);
      reset_count = 1'b0;
      step(236);
      check_sec("t6_pre", 4'd5, 4'd9);
      step(2);
      fast_watch = 1'b1;
      step(1);
      check("t6_om_rise", {31'd0, one_minute}, 32'd0);
      check("t6_os_rise", {31'd0, one_second}, 32'd0);
      step(1);
      check("t6_om_tick", {31'd0, one_minute}, 32'd1);
      check("t6_os_tick", {31'd0, one_second}, 32'd1);
      check_sec("t6_sec", 4'd0, 4'd0);
      fast_watch = 1'b0;
      om_cnt = 0;
      for (int i = 1; i <= 8; i++) begin
         step(1);
         if (one_minute === 1'b1) om_cnt++;
      end
      check("t6_om_after", om_cnt, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
